// File: rtl/pattern_scan_counter.sv
// pattern_scan_counter
// Statistics stage for the LFSR test path. Accepts one word per handshake,
// shifts it out MSB-first one bit per clock through a PAT_W-bit sliding
// window, and flags every window equal to PATTERN. Matches are counted per
// word (word_hits, reported with done) and in a saturating running total
// (match_count, with sticky count_sat).
module pattern_scan_counter #(
    parameter int               WORD_W  = 16,
    parameter int               PAT_W   = 12,
    parameter logic [PAT_W-1:0] PATTERN = 12'b001011111000,
    parameter int               CNT_W   = 16,
    parameter bit               OVERLAP = 1'b1,
    localparam int              HIT_W   = $clog2(WORD_W + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              word_valid,
    input  logic [WORD_W-1:0] word_in,
    output logic              word_ready,
    input  logic              clear_count,
    output logic              busy,
    output logic              match_pulse,
    output logic [CNT_W-1:0]  match_count,
    output logic              count_sat,
    output logic              done,
    output logic [HIT_W-1:0]  word_hits
);

    // Counters that range over 0..WORD_W bits.
    localparam int              BS_W     = $clog2(WORD_W + 1);
    // A window is complete once PAT_W-1 bits were seen before the current one.
    localparam logic [BS_W-1:0] PAT_M1   = BS_W'(PAT_W - 1);
    // bit_cnt value while the last bit of the word is being processed.
    localparam logic [BS_W-1:0] LAST_BIT = BS_W'(WORD_W - 1);

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    state_t            state_q,       state_d;
    logic [WORD_W-1:0] shreg_q,       shreg_d;
    logic [PAT_W-1:0]  window_q,      window_d;
    logic [BS_W-1:0]   bits_seen_q,   bits_seen_d;
    logic [BS_W-1:0]   bit_cnt_q,     bit_cnt_d;
    logic [HIT_W-1:0]  hits_q,        hits_d;
    logic              match_pulse_q, match_pulse_d;
    logic              done_q,        done_d;
    logic [HIT_W-1:0]  word_hits_q,   word_hits_d;
    logic [CNT_W-1:0]  match_count_q, match_count_d;
    logic              count_sat_q,   count_sat_d;

    logic              scan_bit;
    logic [PAT_W-1:0]  next_window;
    logic              hit;

    assign scan_bit = shreg_q[WORD_W-1];

    // A one-bit pattern has no history to shift, so the window is the bit itself.
    if (PAT_W == 1) begin : g_win_1
        assign next_window = scan_bit;
    end else begin : g_win_n
        assign next_window = {window_q[PAT_W-2:0], scan_bit};
    end

    // Handshake, bit-serial scan and per-word hit accumulation.
    always_comb begin
        // NOTE: every variable gets a default before any branch so that no path leaves it unassigned and infers a latch.
        state_d       = state_q;
        shreg_d       = shreg_q;
        window_d      = window_q;
        bits_seen_d   = bits_seen_q;
        bit_cnt_d     = bit_cnt_q;
        hits_d        = hits_q;
        match_pulse_d = 1'b0;
        done_d        = 1'b0;
        word_hits_d   = word_hits_q;
        hit           = 1'b0;

        case (state_q)
            IDLE: begin
                if (word_valid) begin
                    // Each word starts with an empty window: matches never span words.
                    shreg_d     = word_in;
                    window_d    = '0;
                    bits_seen_d = '0;
                    bit_cnt_d   = '0;
                    hits_d      = '0;
                    state_d     = SCAN;
                end
            end

            SCAN: begin
                shreg_d   = {shreg_q[WORD_W-2:0], 1'b0};
                window_d  = next_window;
                hit       = (bits_seen_q >= PAT_M1) && (next_window == PATTERN);
                bit_cnt_d = bit_cnt_q + 1'b1;

                // Without overlap a match consumes its bits; PAT_W fresh ones are needed.
                if (hit && !OVERLAP) begin
                    bits_seen_d = '0;
                end else begin
                    bits_seen_d = bits_seen_q + 1'b1;
                end

                if (hit) begin
                    hits_d = hits_q + 1'b1;
                end
                match_pulse_d = hit;

                // The final bit's own match is already folded into hits_d.
                if (bit_cnt_q == LAST_BIT) begin
                    done_d      = 1'b1;
                    word_hits_d = hits_d;
                    state_d     = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Saturating running total; a clear on the same edge as a match wins.
    always_comb begin
        match_count_d = match_count_q;
        count_sat_d   = count_sat_q;
        if (clear_count) begin
            match_count_d = '0;
            count_sat_d   = 1'b0;
        end else if (hit) begin
            if (match_count_q == {CNT_W{1'b1}}) begin
                count_sat_d = 1'b1;
            end else begin
                match_count_d = match_count_q + 1'b1;
            end
        end
    end

    // State register with synchronous reset; a reset mid-scan drops the word silently.
    always_ff @(posedge clk) begin
        // NOTE: registers use non-blocking assignments so every flop samples the pre-edge values of the others.
        if (reset) begin
            state_q       <= IDLE;
            shreg_q       <= '0;
            window_q      <= '0;
            bits_seen_q   <= '0;
            bit_cnt_q     <= '0;
            hits_q        <= '0;
            match_pulse_q <= 1'b0;
            done_q        <= 1'b0;
            word_hits_q   <= '0;
            match_count_q <= '0;
            count_sat_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            shreg_q       <= shreg_d;
            window_q      <= window_d;
            bits_seen_q   <= bits_seen_d;
            bit_cnt_q     <= bit_cnt_d;
            hits_q        <= hits_d;
            match_pulse_q <= match_pulse_d;
            done_q        <= done_d;
            word_hits_q   <= word_hits_d;
            match_count_q <= match_count_d;
            count_sat_q   <= count_sat_d;
        end
    end

    assign word_ready  = (state_q == IDLE);
    assign busy        = (state_q == SCAN);
    assign match_pulse = match_pulse_q;
    assign done        = done_q;
    assign word_hits   = word_hits_q;
    assign match_count = match_count_q;
    assign count_sat   = count_sat_q;

endmodule

// File: tb/tb_pattern_scan_counter.sv
// Bench for pattern_scan_counter: three instances share one stimulus stream
// (default config, PAT_W=4/1010 overlapping with a 3-bit total, and PAT_W=4/1010
// non-overlapping). A table of words with hand-derived expectations is applied
// in a loop through a scoreboard queue; reset, back-to-back and clear-vs-match
// corner cases are written out by hand.
module tb_pattern_scan_counter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        word_valid = 1'b0;
    logic [15:0] word_in = '0;
    logic        clear_count = 1'b0;

    logic        d_ready, d_busy, d_pulse, d_sat, d_done;
    logic [15:0] d_cnt;
    logic [4:0]  d_hits;
    logic        o_ready, o_busy, o_pulse, o_sat, o_done;
    logic [2:0]  o_cnt;
    logic [4:0]  o_hits;
    logic        n_ready, n_busy, n_pulse, n_sat, n_done;
    logic [15:0] n_cnt;
    logic [4:0]  n_hits;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pattern_scan_counter dut_def (
        .clk(clk), .reset(reset), .word_valid(word_valid), .word_in(word_in),
        .word_ready(d_ready), .clear_count(clear_count), .busy(d_busy),
        .match_pulse(d_pulse), .match_count(d_cnt), .count_sat(d_sat),
        .done(d_done), .word_hits(d_hits)
    );

    pattern_scan_counter #(.PAT_W(4), .PATTERN(4'b1010), .CNT_W(3), .OVERLAP(1'b1)) dut_ov (
        .clk(clk), .reset(reset), .word_valid(word_valid), .word_in(word_in),
        .word_ready(o_ready), .clear_count(clear_count), .busy(o_busy),
        .match_pulse(o_pulse), .match_count(o_cnt), .count_sat(o_sat),
        .done(o_done), .word_hits(o_hits)
    );

    pattern_scan_counter #(.PAT_W(4), .PATTERN(4'b1010), .OVERLAP(1'b0)) dut_no (
        .clk(clk), .reset(reset), .word_valid(word_valid), .word_in(word_in),
        .word_ready(n_ready), .clear_count(clear_count), .busy(n_busy),
        .match_pulse(n_pulse), .match_count(n_cnt), .count_sat(n_sat),
        .done(n_done), .word_hits(n_hits)
    );

    // Pulse masks: bit k-1 set means match_pulse is high in the cycle after edge Ek.
    typedef struct {
        logic        clr;
        logic [15:0] word;
        logic [4:0]  h_def, h_ov, h_no;
        logic [15:0] pm_def, pm_ov, pm_no;
        logic [15:0] c_def;
        logic [2:0]  c_ov;
        logic        s_ov;
        logic [15:0] c_no;
    } vec_t;

    vec_t vecs[6];
    vec_t fresh;
    vec_t exp_q[$];
    vec_t last_exp;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Accept one word at E0, observe 16 scan cycles, then compare with the scoreboard entry.
    task automatic scan_word(input int idx, input vec_t v);
        logic [15:0] pmd, pmo, pmn, dmask, bmask;
        logic [4:0]  hd, ho, hn;
        logic        rdy_after;
        vec_t        e;
        pmd = '0; pmo = '0; pmn = '0; dmask = '0; bmask = '0;
        hd = '0; ho = '0; hn = '0; rdy_after = 1'b0;

        if (v.clr) begin
            clear_count = 1'b1;
            @(posedge clk);
            #1;
            clear_count = 1'b0;
            check($sformatf("v%0d_clr_cnt_def", idx), d_cnt, 0);
            check($sformatf("v%0d_clr_sat_ov", idx), o_sat, 0);
            check($sformatf("v%0d_clr_keeps_hits_ov", idx), o_hits, last_exp.h_ov);
        end

        word_in    = v.word;
        word_valid = 1'b1;
        @(posedge clk);
        exp_q.push_back(v);
        #1;
        word_valid = 1'b0;
        check($sformatf("v%0d_accept_busy", idx), d_busy, 1);
        check($sformatf("v%0d_accept_ready", idx), d_ready, 0);

        for (int k = 1; k <= 16; k++) begin
            @(posedge clk);
            #1;
            pmd[k-1]   = d_pulse;
            pmo[k-1]   = o_pulse;
            pmn[k-1]   = n_pulse;
            dmask[k-1] = d_done;
            bmask[k-1] = d_busy;
            if (k == 16) begin
                hd        = d_hits;
                ho        = o_hits;
                hn        = n_hits;
                rdy_after = d_ready;
            end
        end

        e = exp_q.pop_front();
        check($sformatf("v%0d_pulses_def", idx), pmd, e.pm_def);
        check($sformatf("v%0d_pulses_ov", idx), pmo, e.pm_ov);
        check($sformatf("v%0d_pulses_no", idx), pmn, e.pm_no);
        check($sformatf("v%0d_done_timing", idx), dmask, 16'h8000);
        check($sformatf("v%0d_busy_cycles", idx), bmask, 16'h7FFF);
        check($sformatf("v%0d_ready_after", idx), rdy_after, 1);
        check($sformatf("v%0d_hits_def", idx), hd, e.h_def);
        check($sformatf("v%0d_hits_ov", idx), ho, e.h_ov);
        check($sformatf("v%0d_hits_no", idx), hn, e.h_no);
        check($sformatf("v%0d_cnt_def", idx), d_cnt, e.c_def);
        check($sformatf("v%0d_cnt_ov", idx), o_cnt, e.c_ov);
        check($sformatf("v%0d_sat_ov", idx), o_sat, e.s_ov);
        check($sformatf("v%0d_cnt_no", idx), n_cnt, e.c_no);
        last_exp = e;
    endtask

    initial begin
        int          acc_cyc[$];
        logic        prev_busy;
        int          n_done;
        int          ready_bad;
        logic        done_seen;

        // 2F80: 001011111000 ends at bit 12. AAAA under 1010: overlap hits bits 4,6..16,
        // non-overlap hits bits 4,8,12,16. The 3-bit total saturates on the second AAAA.
        vecs[0] = '{clr: 1'b0, word: 16'h2F80, h_def: 5'd1, h_ov: 5'd0, h_no: 5'd0,
                    pm_def: 16'h0800, pm_ov: 16'h0000, pm_no: 16'h0000,
                    c_def: 16'd1, c_ov: 3'd0, s_ov: 1'b0, c_no: 16'd0};
        vecs[1] = '{clr: 1'b0, word: 16'hAAAA, h_def: 5'd0, h_ov: 5'd7, h_no: 5'd4,
                    pm_def: 16'h0000, pm_ov: 16'hAAA8, pm_no: 16'h8888,
                    c_def: 16'd1, c_ov: 3'd7, s_ov: 1'b0, c_no: 16'd4};
        vecs[2] = '{clr: 1'b0, word: 16'hAAAA, h_def: 5'd0, h_ov: 5'd7, h_no: 5'd4,
                    pm_def: 16'h0000, pm_ov: 16'hAAA8, pm_no: 16'h8888,
                    c_def: 16'd1, c_ov: 3'd7, s_ov: 1'b1, c_no: 16'd8};
        // Pattern straddling the 0002/F800 boundary must not be found.
        vecs[3] = '{clr: 1'b1, word: 16'h0002, h_def: 5'd0, h_ov: 5'd0, h_no: 5'd0,
                    pm_def: 16'h0000, pm_ov: 16'h0000, pm_no: 16'h0000,
                    c_def: 16'd0, c_ov: 3'd0, s_ov: 1'b0, c_no: 16'd0};
        vecs[4] = '{clr: 1'b0, word: 16'hF800, h_def: 5'd0, h_ov: 5'd0, h_no: 5'd0,
                    pm_def: 16'h0000, pm_ov: 16'h0000, pm_no: 16'h0000,
                    c_def: 16'd0, c_ov: 3'd0, s_ov: 1'b0, c_no: 16'd0};
        vecs[5] = '{clr: 1'b0, word: 16'h2F80, h_def: 5'd1, h_ov: 5'd0, h_no: 5'd0,
                    pm_def: 16'h0800, pm_ov: 16'h0000, pm_no: 16'h0000,
                    c_def: 16'd1, c_ov: 3'd0, s_ov: 1'b0, c_no: 16'd0};
        fresh   = vecs[5];

        // Reset values.
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", d_ready, 1);
        check("rst_busy", d_busy, 0);
        check("rst_pulse", d_pulse, 0);
        check("rst_done", d_done, 0);
        check("rst_cnt_def", d_cnt, 0);
        check("rst_sat_def", d_sat, 0);
        check("rst_hits_def", d_hits, 0);
        check("rst_cnt_ov", o_cnt, 0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 6; i++) begin
            scan_word(i, vecs[i]);
        end

        // Reset sampled at E8 of a scan: no done, totals cleared, ready next cycle.
        word_in    = 16'h2F80;
        word_valid = 1'b1;
        @(posedge clk);
        #1;
        word_valid = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("midrst_ready", d_ready, 1);
        check("midrst_busy", d_busy, 0);
        check("midrst_cnt_def", d_cnt, 0);
        check("midrst_hits_def", d_hits, 0);
        done_seen = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            #1;
            if (d_done) done_seen = 1'b1;
        end
        check("midrst_no_done", done_seen, 0);
        scan_word(6, fresh);

        // Back-to-back AAAA with word_valid held; clear_count on the E4 match of word 2.
        acc_cyc.delete();
        prev_busy  = 1'b0;
        n_done     = 0;
        ready_bad  = 0;
        word_in    = 16'hAAAA;
        word_valid = 1'b1;
        for (int c = 0; c < 51; c++) begin
            @(posedge clk);
            #1;
            if (d_busy && !prev_busy) acc_cyc.push_back(c);
            prev_busy = d_busy;
            if (d_busy && d_ready) ready_bad++;
            if (acc_cyc.size() == 2 && c - acc_cyc[1] == 4) begin
                check("clr_match_pulse_ov", o_pulse, 1);
                check("clr_match_pulse_no", n_pulse, 1);
                check("clr_match_cnt_ov", o_cnt, 0);
                check("clr_match_sat_ov", o_sat, 0);
                check("clr_match_cnt_no", n_cnt, 0);
                clear_count = 1'b0;
            end
            if (acc_cyc.size() == 2 && c - acc_cyc[1] == 3) clear_count = 1'b1;
            if (o_done) begin
                n_done++;
                check($sformatf("b2b_hits_ov_%0d", n_done), o_hits, 7);
                check($sformatf("b2b_hits_no_%0d", n_done), n_hits, 4);
                check($sformatf("b2b_hits_def_%0d", n_done), d_hits, 0);
            end
        end
        word_valid  = 1'b0;
        clear_count = 1'b0;
        check("b2b_accepts", acc_cyc.size(), 3);
        check("b2b_gap1", (acc_cyc.size() >= 2) ? acc_cyc[1] - acc_cyc[0] : -1, 17);
        check("b2b_gap2", (acc_cyc.size() >= 3) ? acc_cyc[2] - acc_cyc[1] : -1, 17);
        check("b2b_dones", n_done, 3);
        check("b2b_ready_while_busy", ready_bad, 0);
        // ov: 7, cleared at bit 4, +6, then +1 and saturated. no: 4, cleared, +3, +4.
        check("b2b_cnt_ov", o_cnt, 7);
        check("b2b_sat_ov", o_sat, 1);
        check("b2b_cnt_no", n_cnt, 7);
        check("b2b_cnt_def", d_cnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
